// File: rtl/iterator_pkg.sv
// Shared constants, write-mode encoding and operand decode for the iterator table.
// Latency: none, declarations only.
// Backpressure: not applicable.
package iterator_pkg;

    localparam int DEF_NS_ID_BITS       = 3;
    localparam int DEF_NS_INDEX_ID_BITS = 5;
    localparam int DEF_IMM_W            = 2 * (DEF_NS_ID_BITS + DEF_NS_INDEX_ID_BITS);
    localparam int DEF_ADDR_WIDTH       = 2 * DEF_IMM_W;

    localparam logic [3:0] OP_ALU   = 4'b0000;
    localparam logic [3:0] OP_CALC  = 4'b0001;
    localparam logic [3:0] OP_CMP   = 4'b0010;
    localparam logic [3:0] OP_NLIN  = 4'b0011;
    localparam logic [3:0] OP_ITER  = 4'b0110;
    localparam logic [3:0] OP_DTYPE = 4'b0111;
    localparam logic [3:0] FN_BOUND = 4'b1100;
    localparam logic [3:0] FN_NOP   = 4'b1111;

    typedef enum logic [1:0] {
        WR_SEXT = 2'b00,
        WR_HI   = 2'b01,
        WR_HILO = 2'b10,
        WR_ZEXT = 2'b11
    } wr_mode_e;

    typedef struct packed {
        logic src1;
        logic src2;
        logic dest;
    } op_vld_t;

    function automatic op_vld_t decode_op_vld(input logic [3:0] op, input logic [3:0] fn);
        op_vld_t v;
        v = '0;
        case (op)
            OP_ALU: begin
                v.src1 = (fn != FN_NOP);
                v.src2 = (fn != FN_NOP);
                v.dest = (fn != FN_NOP);
            end
            OP_CMP, OP_NLIN, OP_DTYPE: begin
                v.src1 = 1'b1;
                v.src2 = 1'b1;
                v.dest = 1'b1;
            end
            OP_CALC: begin
                v.src1 = 1'b1;
                v.dest = 1'b1;
                v.src2 = (fn == 4'b0001) || (fn == 4'b0010) || (fn == 4'b0011);
            end
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/iterator_entry_bank.sv
// Per-namespace iterator storage (start/base/stride/bound/count) with wrap-on-bound stepping.
// Latency: reads are combinational from flops; writes and steps land at the next edge.
// Backpressure: none; the caller only asserts writes/steps on accepted instructions.
module iterator_entry_bank #(
    parameter int IDX_BITS   = 5,
    parameter int IMM_W      = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [2:0][IDX_BITS-1:0]        rd_idx,
    output logic [2:0][ADDR_WIDTH-1:0]      rd_base,
    input  logic                            wr_en,
    input  logic                            wr_stride,
    input  logic [IDX_BITS-1:0]             wr_idx,
    input  logic [ADDR_WIDTH-1:0]           wr_data,
    input  logic                            bnd_en,
    input  logic [IMM_W-1:0]                bnd_data,
    input  logic [2:0]                      step_en,
    input  logic [2:0][IDX_BITS-1:0]        step_idx
);

    localparam int DEPTH = 2 ** IDX_BITS;

    logic [ADDR_WIDTH-1:0] base_q   [DEPTH];
    logic [ADDR_WIDTH-1:0] stride_q [DEPTH];
    logic [ADDR_WIDTH-1:0] start_q  [DEPTH];
    logic [IMM_W-1:0]      bound_q  [DEPTH];
    logic [IMM_W-1:0]      count_q  [DEPTH];
    logic [DEPTH-1:0]      step_hit;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            rd_base[k] = base_q[rd_idx[k]];
        end
    end

    // Several lanes naming one entry collapse into a single step.
    always_comb begin
        step_hit = '0;
        for (int e = 0; e < DEPTH; e++) begin
            for (int k = 0; k < 3; k++) begin
                if (step_en[k] && (step_idx[k] == IDX_BITS'(e))) begin
                    step_hit[e] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                base_q[e]   <= '0;
                stride_q[e] <= '0;
                start_q[e]  <= '0;
                bound_q[e]  <= '0;
                count_q[e]  <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (wr_en && (wr_idx == IDX_BITS'(e))) begin
                    if (wr_stride) begin
                        stride_q[e] <= wr_data;
                    end else begin
                        base_q[e]  <= wr_data;
                        start_q[e] <= wr_data;
                        count_q[e] <= '0;
                    end
                end else if (bnd_en && (wr_idx == IDX_BITS'(e))) begin
                    bound_q[e] <= bnd_data;
                end else if (step_hit[e]) begin
                    if ((bound_q[e] == '0) ||
                        (({1'b0, count_q[e]} + (IMM_W+1)'(1)) < {1'b0, bound_q[e]})) begin
                        base_q[e]  <= base_q[e] + stride_q[e];
                        count_q[e] <= count_q[e] + IMM_W'(1);
                    end else begin
                        base_q[e]  <= start_q[e];
                        count_q[e] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/iterator_table_gen.sv
// Decodes iterator config/compute instructions and returns registered src1/src2/dest addresses.
// Latency: one cycle from accepted compute instruction to addr_valid.
// Backpressure: inst_ready drops while a bundle is held and addr_ready is low.
module iterator_table_gen
    import iterator_pkg::*;
#(
    parameter int NUM_NS           = 6,
    parameter int NS_ID_BITS       = DEF_NS_ID_BITS,
    parameter int NS_INDEX_ID_BITS = DEF_NS_INDEX_ID_BITS,
    parameter int OPCODE_BITS      = 4,
    parameter int FUNCTION_BITS    = 4,
    parameter int IMM_W            = 2 * (NS_ID_BITS + NS_INDEX_ID_BITS),
    parameter int ADDR_WIDTH       = 2 * IMM_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        inst_valid,
    output logic                        inst_ready,
    input  logic [OPCODE_BITS-1:0]      opcode,
    input  logic [FUNCTION_BITS-1:0]    fn,
    input  logic [NS_ID_BITS-1:0]       dest_ns_id,
    input  logic [NS_INDEX_ID_BITS-1:0] dest_ns_index_id,
    input  logic [NS_ID_BITS-1:0]       src1_ns_id,
    input  logic [NS_INDEX_ID_BITS-1:0] src1_ns_index_id,
    input  logic [NS_ID_BITS-1:0]       src2_ns_id,
    input  logic [NS_INDEX_ID_BITS-1:0] src2_ns_index_id,
    input  logic                        loop_step,
    output logic                        addr_valid,
    input  logic                        addr_ready,
    output logic [ADDR_WIDTH-1:0]       src1_addr,
    output logic [ADDR_WIDTH-1:0]       src2_addr,
    output logic [ADDR_WIDTH-1:0]       dest_addr,
    output logic                        src1_en,
    output logic                        src2_en,
    output logic                        dest_en,
    output logic [NS_ID_BITS-1:0]       src1_ns,
    output logic [NS_ID_BITS-1:0]       src2_ns,
    output logic [NS_ID_BITS-1:0]       dest_ns,
    output logic                        cfg_err
);

    logic [IMM_W-1:0]                   imm;
    logic [IMM_W-1:0]                   hi_stage;
    logic                               accept;
    logic                               is_cfg;
    logic                               cfg_wr;
    logic                               bnd_wr;
    wr_mode_e                           mode;
    op_vld_t                            dec;
    logic [2:0]                         used;
    logic [2:0]                         legal;
    logic [2:0]                         dup;
    logic [2:0]                         step_k;
    logic [2:0][NS_ID_BITS-1:0]         ns_k;
    logic [2:0][NS_INDEX_ID_BITS-1:0]   idx_k;
    logic [2:0][ADDR_WIDTH-1:0]         rd_addr;
    logic [2:0][ADDR_WIDTH-1:0]         bank_base [NUM_NS];
    logic [ADDR_WIDTH-1:0]              wr_data;
    logic                               cfg_err_nxt;

    assign imm        = {src1_ns_id, src1_ns_index_id, src2_ns_id, src2_ns_index_id};
    assign inst_ready = ~addr_valid | addr_ready;
    assign accept     = inst_valid & inst_ready;
    assign is_cfg     = (opcode == OP_ITER) && !fn[3];
    assign mode       = wr_mode_e'(fn[1:0]);
    assign cfg_wr     = is_cfg && (mode != WR_HI);
    assign bnd_wr     = (opcode == OP_ITER) && (fn == FN_BOUND);
    assign dec        = decode_op_vld(opcode, fn);
    assign used       = {dec.dest, dec.src2, dec.src1};
    assign ns_k       = {dest_ns_id, src2_ns_id, src1_ns_id};
    assign idx_k      = {dest_ns_index_id, src2_ns_index_id, src1_ns_index_id};

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            legal[k] = (32'(ns_k[k]) < NUM_NS);
        end
    end

    // A later operand naming the same live entry as an earlier one does not step again.
    always_comb begin
        dup[0] = 1'b0;
        dup[1] = used[0] && legal[0] && (ns_k[0] == ns_k[1]) && (idx_k[0] == idx_k[1]);
        dup[2] = (used[0] && legal[0] && (ns_k[0] == ns_k[2]) && (idx_k[0] == idx_k[2])) ||
                 (used[1] && legal[1] && (ns_k[1] == ns_k[2]) && (idx_k[1] == idx_k[2]));
        for (int k = 0; k < 3; k++) begin
            step_k[k] = accept && loop_step && used[k] && legal[k] && !dup[k];
        end
    end

    always_comb begin
        case (mode)
            WR_SEXT: wr_data = {{IMM_W{imm[IMM_W-1]}}, imm};
            WR_HILO: wr_data = {hi_stage, imm};
            default: wr_data = {{IMM_W{1'b0}}, imm};
        endcase
    end

    assign cfg_err_nxt = accept && ((((cfg_wr || bnd_wr) && !legal[2])) || (|(used & ~legal)));

    for (genvar n = 0; n < NUM_NS; n++) begin : g_bank
        logic [2:0] bank_step;
        logic       bank_sel;

        assign bank_sel = accept && legal[2] && (dest_ns_id == NS_ID_BITS'(n));

        always_comb begin
            for (int k = 0; k < 3; k++) begin
                bank_step[k] = step_k[k] && (ns_k[k] == NS_ID_BITS'(n));
            end
        end

        iterator_entry_bank #(
            .IDX_BITS   (NS_INDEX_ID_BITS),
            .IMM_W      (IMM_W),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk       (clk),
            .reset     (reset),
            .rd_idx    (idx_k),
            .rd_base   (bank_base[n]),
            .wr_en     (bank_sel && cfg_wr),
            .wr_stride (fn[2]),
            .wr_idx    (dest_ns_index_id),
            .wr_data   (wr_data),
            .bnd_en    (bank_sel && bnd_wr),
            .bnd_data  (imm),
            .step_en   (bank_step),
            .step_idx  (idx_k)
        );
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            rd_addr[k] = '0;
            for (int n = 0; n < NUM_NS; n++) begin
                if (used[k] && (ns_k[k] == NS_ID_BITS'(n))) begin
                    rd_addr[k] = bank_base[n][k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_valid <= 1'b0;
            src1_addr  <= '0;
            src2_addr  <= '0;
            dest_addr  <= '0;
            src1_en    <= 1'b0;
            src2_en    <= 1'b0;
            dest_en    <= 1'b0;
            src1_ns    <= '0;
            src2_ns    <= '0;
            dest_ns    <= '0;
            cfg_err    <= 1'b0;
            hi_stage   <= '0;
        end else begin
            cfg_err <= cfg_err_nxt;
            if (accept && is_cfg && (mode == WR_HI)) begin
                hi_stage <= imm;
            end
            if (inst_ready) begin
                addr_valid <= inst_valid && (|used);
                if (inst_valid && (|used)) begin
                    src1_addr <= rd_addr[0];
                    src2_addr <= rd_addr[1];
                    dest_addr <= rd_addr[2];
                    src1_en   <= used[0] && legal[0];
                    src2_en   <= used[1] && legal[1];
                    dest_en   <= used[2] && legal[2];
                    src1_ns   <= (used[0] && legal[0]) ? ns_k[0] : '0;
                    src2_ns   <= (used[1] && legal[1]) ? ns_k[1] : '0;
                    dest_ns   <= (used[2] && legal[2]) ? ns_k[2] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_iterator_table_gen.sv
// Directed and randomized bench for iterator_table_gen against a transaction-level table model.
// Inputs change and outputs are sampled on the falling edge.
module tb_iterator_table_gen;

    localparam int NUM_NS = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [3:0]  opcode = '0;
    logic [3:0]  fn = '0;
    logic [2:0]  dest_ns_id = '0, src1_ns_id = '0, src2_ns_id = '0;
    logic [4:0]  dest_ns_index_id = '0, src1_ns_index_id = '0, src2_ns_index_id = '0;
    logic        loop_step = 1'b0;
    logic        addr_valid;
    logic        addr_ready = 1'b0;
    logic [31:0] src1_addr, src2_addr, dest_addr;
    logic        src1_en, src2_en, dest_en;
    logic [2:0]  src1_ns, src2_ns, dest_ns;
    logic        cfg_err;

    always #5 clk = ~clk;

    iterator_table_gen dut (
        .clk              (clk),
        .reset            (reset),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .opcode           (opcode),
        .fn               (fn),
        .dest_ns_id       (dest_ns_id),
        .dest_ns_index_id (dest_ns_index_id),
        .src1_ns_id       (src1_ns_id),
        .src1_ns_index_id (src1_ns_index_id),
        .src2_ns_id       (src2_ns_id),
        .src2_ns_index_id (src2_ns_index_id),
        .loop_step        (loop_step),
        .addr_valid       (addr_valid),
        .addr_ready       (addr_ready),
        .src1_addr        (src1_addr),
        .src2_addr        (src2_addr),
        .dest_addr        (dest_addr),
        .src1_en          (src1_en),
        .src2_en          (src2_en),
        .dest_en          (dest_en),
        .src1_ns          (src1_ns),
        .src2_ns          (src2_ns),
        .dest_ns          (dest_ns),
        .cfg_err          (cfg_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: tables indexed [ns][idx], plus the one outstanding bundle.
    logic [31:0] m_base   [8][32];
    logic [31:0] m_stride [8][32];
    logic [31:0] m_start  [8][32];
    logic [15:0] m_bound  [8][32];
    logic [15:0] m_count  [8][32];
    logic [15:0] m_hi;
    logic        m_vld, m_err;
    logic [31:0] m_addr [3];
    logic        m_en   [3];
    logic [2:0]  m_ns   [3];

    task automatic model_reset();
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 32; i++) begin
                m_base[n][i] = 0; m_stride[n][i] = 0; m_start[n][i] = 0;
                m_bound[n][i] = 0; m_count[n][i] = 0;
            end
        end
        m_hi = 0; m_vld = 0; m_err = 0;
        for (int k = 0; k < 3; k++) begin
            m_addr[k] = 0; m_en[k] = 0; m_ns[k] = 0;
        end
    endtask

    task automatic model_accept();
        logic [15:0] imm;
        logic [31:0] v;
        logic [2:0]  ns [3];
        logic [4:0]  ix [3];
        logic        use_op [3];
        logic        dup;
        imm = {src1_ns_id, src1_ns_index_id, src2_ns_id, src2_ns_index_id};
        ns = '{src1_ns_id, src2_ns_id, dest_ns_id};
        ix = '{src1_ns_index_id, src2_ns_index_id, dest_ns_index_id};
        m_err = 0;
        m_vld = 0;
        for (int k = 0; k < 3; k++) begin
            m_en[k] = 0; m_addr[k] = 0; m_ns[k] = 0; use_op[k] = 0;
        end
        if (opcode == 4'b0110) begin
            if (!fn[3]) begin
                if (fn[1:0] == 2'b01) begin
                    m_hi = imm;
                end else if (dest_ns_id >= NUM_NS) begin
                    m_err = 1;
                end else begin
                    case (fn[1:0])
                        2'b00:   v = {{16{imm[15]}}, imm};
                        2'b10:   v = {m_hi, imm};
                        default: v = {16'h0000, imm};
                    endcase
                    if (fn[2]) begin
                        m_stride[dest_ns_id][dest_ns_index_id] = v;
                    end else begin
                        m_base[dest_ns_id][dest_ns_index_id]  = v;
                        m_start[dest_ns_id][dest_ns_index_id] = v;
                        m_count[dest_ns_id][dest_ns_index_id] = 0;
                    end
                end
            end else if (fn == 4'b1100) begin
                if (dest_ns_id >= NUM_NS) m_err = 1;
                else m_bound[dest_ns_id][dest_ns_index_id] = imm;
            end
        end else begin
            case (opcode)
                4'b0000: for (int k = 0; k < 3; k++) use_op[k] = (fn != 4'b1111);
                4'b0010, 4'b0011, 4'b0111: for (int k = 0; k < 3; k++) use_op[k] = 1;
                4'b0001: begin
                    use_op[0] = 1;
                    use_op[2] = 1;
                    use_op[1] = fn inside {4'b0001, 4'b0010, 4'b0011};
                end
                default: ;
            endcase
            for (int k = 0; k < 3; k++) begin
                if (use_op[k]) begin
                    m_vld = 1;
                    if (ns[k] < NUM_NS) begin
                        m_en[k]   = 1;
                        m_addr[k] = m_base[ns[k]][ix[k]];
                        m_ns[k]   = ns[k];
                    end else begin
                        m_err = 1;
                    end
                end
            end
            if (loop_step) begin
                for (int k = 0; k < 3; k++) begin
                    dup = 0;
                    for (int j = 0; j < k; j++) begin
                        if (m_en[j] && ns[j] == ns[k] && ix[j] == ix[k]) dup = 1;
                    end
                    if (m_en[k] && !dup) begin
                        if (m_bound[ns[k]][ix[k]] == 0 ||
                            32'(m_count[ns[k]][ix[k]]) + 1 < 32'(m_bound[ns[k]][ix[k]])) begin
                            m_base[ns[k]][ix[k]]  = m_base[ns[k]][ix[k]] + m_stride[ns[k]][ix[k]];
                            m_count[ns[k]][ix[k]] = m_count[ns[k]][ix[k]] + 1;
                        end else begin
                            m_base[ns[k]][ix[k]]  = m_start[ns[k]][ix[k]];
                            m_count[ns[k]][ix[k]] = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("addr_valid", addr_valid, m_vld);
        check_eq("cfg_err", cfg_err, m_err);
        if (m_vld) begin
            check_eq("src1_addr", src1_addr, m_addr[0]);
            check_eq("src2_addr", src2_addr, m_addr[1]);
            check_eq("dest_addr", dest_addr, m_addr[2]);
            check_eq("src1_en", src1_en, m_en[0]);
            check_eq("src2_en", src2_en, m_en[1]);
            check_eq("dest_en", dest_en, m_en[2]);
            check_eq("src1_ns", src1_ns, m_ns[0]);
            check_eq("src2_ns", src2_ns, m_ns[1]);
            check_eq("dest_ns", dest_ns, m_ns[2]);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs checked.
    task automatic drive(input logic v, input logic rdy, output logic acc);
        inst_valid = v;
        addr_ready = rdy;
        #1;
        check_eq("inst_ready", inst_ready, !m_vld || rdy);
        acc = v && (!m_vld || rdy);
        if (acc) begin
            model_accept();
        end else begin
            m_err = 0;
            if (rdy) m_vld = 0;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_inst(input logic [3:0] op, input logic [3:0] f,
                            input logic [2:0] s1n, input logic [4:0] s1i,
                            input logic [2:0] s2n, input logic [4:0] s2i,
                            input logic [2:0] dn, input logic [4:0] di, input logic stp);
        opcode = op; fn = f;
        src1_ns_id = s1n; src1_ns_index_id = s1i;
        src2_ns_id = s2n; src2_ns_index_id = s2i;
        dest_ns_id = dn; dest_ns_index_id = di;
        loop_step = stp;
    endtask

    task automatic cfg(input logic [3:0] f, input logic [2:0] dn, input logic [4:0] di,
                       input logic [15:0] imm);
        logic acc;
        set_inst(4'b0110, f, imm[15:13], imm[12:8], imm[7:5], imm[4:0], dn, di, 1'b0);
        drive(1'b1, 1'b1, acc);
    endtask

    task automatic comp(input logic [3:0] op, input logic [3:0] f,
                        input logic [2:0] s1n, input logic [4:0] s1i,
                        input logic [2:0] s2n, input logic [4:0] s2i,
                        input logic [2:0] dn, input logic [4:0] di, input logic stp);
        logic acc;
        set_inst(op, f, s1n, s1i, s2n, s2i, dn, di, stp);
        drive(1'b1, 1'b1, acc);
    endtask

    function automatic logic [2:0] rand_ns();
        return ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
    endfunction

    logic [3:0] op_tab [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h6, 4'h6, 4'h6, 4'h5, 4'hF};
    logic [3:0] fn_tab [8]  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'hC};
    logic [31:0] expect_seq [3];

    initial begin
        logic acc;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_addr_valid", addr_valid, 0);
        check_eq("rst_inst_ready", inst_ready, 1);
        check_eq("rst_cfg_err", cfg_err, 0);
        check_eq("rst_dest_addr", dest_addr, 0);
        check_eq("rst_src1_en", src1_en, 0);
        reset = 1'b1;
        @(negedge clk);

        // Stride stepping with back-to-back reads of the updated base.
        cfg(4'b0000, 3'd2, 5'd3, 16'h0040);
        cfg(4'b0100, 3'd2, 5'd3, 16'h0004);
        expect_seq = '{32'h40, 32'h44, 32'h48};
        for (int i = 0; i < 3; i++) begin
            comp(4'b0010, 4'b0000, 3'd2, 5'd3, 3'd0, 5'd0, 3'd2, 5'd3, 1'b1);
            check_eq("step_dest", dest_addr, expect_seq[i]);
            check_eq("step_src1", src1_addr, expect_seq[i]);
        end

        // Bounded wrap back to start.
        cfg(4'b0000, 3'd2, 5'd3, 16'h0040);
        cfg(4'b1100, 3'd2, 5'd3, 16'h0002);
        expect_seq = '{32'h40, 32'h44, 32'h40};
        for (int i = 0; i < 3; i++) begin
            comp(4'b0010, 4'b0000, 3'd2, 5'd3, 3'd0, 5'd0, 3'd2, 5'd3, 1'b1);
            check_eq("wrap_dest", dest_addr, expect_seq[i]);
        end

        // Hi/lo and sign-extended base writes.
        cfg(4'b0001, 3'd2, 5'd3, 16'h1234);
        cfg(4'b0010, 3'd2, 5'd3, 16'h5678);
        comp(4'b0010, 4'b0000, 3'd2, 5'd3, 3'd0, 5'd0, 3'd2, 5'd3, 1'b0);
        check_eq("hilo_dest", dest_addr, 32'h12345678);
        cfg(4'b0000, 3'd2, 5'd3, 16'h8000);
        comp(4'b0010, 4'b0000, 3'd2, 5'd3, 3'd0, 5'd0, 3'd2, 5'd3, 1'b0);
        check_eq("sext_dest", dest_addr, 32'hFFFF8000);

        // Consumer stall with a second instruction pending.
        cfg(4'b0000, 3'd2, 5'd3, 16'h0100);
        comp(4'b0010, 4'b0000, 3'd2, 5'd3, 3'd0, 5'd0, 3'd2, 5'd3, 1'b1);
        check_eq("stall_first", dest_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, acc);
            check_eq("stall_inst_ready", inst_ready, 0);
            check_eq("stall_valid", addr_valid, 1);
            check_eq("stall_hold", dest_addr, 32'h100);
        end
        drive(1'b1, 1'b1, acc);
        check_eq("stall_next", dest_addr, 32'h104);

        // Operand-valid decode corners.
        comp(4'b0001, 4'b0100, 3'd1, 5'd1, 3'd1, 5'd2, 3'd1, 5'd3, 1'b0);
        check_eq("calc_src2_en", src2_en, 0);
        check_eq("calc_src1_en", src1_en, 1);
        comp(4'b0000, 4'b1111, 3'd1, 5'd1, 3'd1, 5'd2, 3'd1, 5'd3, 1'b0);
        check_eq("nop_valid", addr_valid, 0);

        // Illegal namespace on config and on a compute operand.
        cfg(4'b0000, 3'd7, 5'd3, 16'h0055);
        check_eq("bad_cfg_err", cfg_err, 1);
        drive(1'b0, 1'b1, acc);
        check_eq("bad_cfg_pulse", cfg_err, 0);
        for (int n = 0; n < NUM_NS; n++) begin
            comp(4'b0010, 4'b0000, 3'(n), 5'd3, 3'(n), 5'd3, 3'(n), 5'd3, 1'b0);
        end
        check_eq("ns0_untouched", dest_addr, 32'h0);
        comp(4'b0010, 4'b0000, 3'd2, 5'd3, 3'd7, 5'd1, 3'd2, 5'd3, 1'b0);
        check_eq("bad_op_err", cfg_err, 1);
        check_eq("bad_op_en", src2_en, 0);
        check_eq("bad_op_addr", src2_addr, 0);

        // Randomized mix with hazards on a few indices and random backpressure.
        for (int i = 0; i < 600; i++) begin
            set_inst(op_tab[$urandom_range(0, 9)], 4'($urandom), rand_ns(), 5'($urandom_range(0, 3)),
                     rand_ns(), 5'($urandom_range(0, 3)), rand_ns(), 5'($urandom_range(0, 3)),
                     1'($urandom));
            if (opcode == 4'b0110) fn = fn_tab[$urandom_range(0, 7)];
            do begin
                drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), acc);
            end while (!acc && inst_valid && ($urandom_range(0, 7) != 0));
        end

        // Reset with a bundle pending drops it and clears the tables.
        comp(4'b0010, 4'b0000, 3'd2, 5'd3, 3'd0, 5'd0, 3'd2, 5'd3, 1'b0);
        addr_ready = 1'b0;
        inst_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_valid", addr_valid, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        comp(4'b0010, 4'b0000, 3'd2, 5'd3, 3'd0, 5'd0, 3'd2, 5'd3, 1'b0);
        check_eq("post_rst_base", dest_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
